mem_burst_reader: RTL and testbench
===================================

Name: mem_burst_reader

Overview:
Read-side controller for the team's simple dual-port RAM (write port A, registered read port B, 1-cycle read latency). It accepts a burst command (start address, length), drives the RAM read address, absorbs the read latency, and presents the words on a valid/ready stream with full backpressure support. It sits between the RAM's port B and any downstream consumer, such as a UART TX or a checksum engine.

Parameters:
DATA_WIDTH, 8, word width; must match the RAM.
DEPTH, 16, RAM depth in words.
ADDR_WIDTH, $clog2(DEPTH), localparam; RAM address width.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  command strobe; sampled only in IDLE.
start_addr  input  ADDR_WIDTH  first word address.
len  input  ADDR_WIDTH+1  number of words to read (0..2*DEPTH-1).
busy  output  1  high from the cycle after start is accepted until done.
done  output  1  one-cycle pulse after the last word is handshaked.
addrb  output  ADDR_WIDTH  RAM read address, driven from the internal read-address register.
doutb  input  DATA_WIDTH  RAM read data; valid the cycle after addrb is presented.
m_data  output  DATA_WIDTH  stream data.
m_valid  output  1  stream valid.
m_ready  input  1  stream ready from the consumer.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0; done=0; m_valid=0; m_data=0; addrb=0; buffer and in-flight flag cleared. Reset mid-burst aborts the burst, discards any in-flight read, and produces no done pulse.
- States: IDLE, READ, DONE.
- IDLE:
  - start=1 and len>0: capture start_addr into rd_addr, len into issue_cnt and out_cnt; go to READ.
  - start=1 and len=0: go to DONE; no reads are issued.
  - start=0: no action.
- READ:
  - Issue condition: issue_cnt>0 and (buf_count + inflight - pop) < 2, where pop = m_valid & m_ready in the current cycle.
  - On issue: rd_addr increments modulo DEPTH (wraps DEPTH-1 to 0), issue_cnt decrements, and inflight is set for the next cycle.
  - In the cycle after an issue, doutb is pushed into a 2-entry output FIFO. The push and pop may occur in the same cycle.
  - Each handshake decrements out_cnt. When the handshake of the last word occurs (out_cnt 1 to 0), go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
- busy=1 in READ only.
- start in READ or DONE is ignored. Command inputs are not re-sampled.
- Stream rules:
  - m_data and m_valid come from the FIFO head.
  - While m_valid=1 and m_ready=0, m_data holds stable and m_valid stays high.
  - No word is lost or duplicated.
  - Words emerge in address order.
- Throughput: 1 word/cycle sustained when m_ready is held high.
- Latency: start sampled in cycle 0; first addrb issue in cycle 1; doutb valid in cycle 2; m_valid=1 from cycle 3.
- The FIFO never overflows: the issue condition guarantees at most 2 entries, counting in-flight reads.
- The RAM is read-only from this block; write-port traffic to addresses being read is outside this block's responsibility.

Test Plan:
1. Reset: assert rst 2 cycles mid-activity -> busy=0, done=0, m_valid=0, m_data=0, addrb=0.
2. RAM preloaded with mem[i]=0xA0+i; start_addr=3, len=4, m_ready=1 -> m_data sequence 0xA3, 0xA4, 0xA5, 0xA6 in cycles 3-6; done pulses in cycle 7; busy high in cycles 1-6.
3. Wrap-around: start_addr=14, len=4 -> addrb sequence 14, 15, 0, 1; data 0xAE, 0xAF, 0xA0, 0xA1.
4. Backpressure: len=16, m_ready pseudo-random (~50%) -> all 16 words delivered in order; m_data stable while stalled; no more than 2 buffered plus in-flight words.
5. len=0 -> no m_valid and no addrb issue; done pulses exactly once, in cycle 1.
6. Start pulsed again while busy (len=4 burst in progress) -> second command ignored; exactly 4 words and one done pulse.

Source files
------------

// File: rtl/mem_burst_reader.sv
// mem_burst_reader
// Read-side burst controller for a simple dual-port RAM with a registered
// read port (1-cycle read latency). A command (start_addr, len) is sampled
// in IDLE; the block then walks the RAM read address (wrapping modulo DEPTH),
// absorbs the read latency in a 2-entry output FIFO and presents the words
// on a valid/ready stream with full backpressure.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             command strobe (sampled in IDLE only)
//   start_addr, len   first word address, number of words (0 allowed)
//   busy              high while the burst is being read (READ state)
//   done              one-cycle pulse after the last word is handshaked
//   addrb             RAM port B read address (registered)
//   doutb             RAM port B read data, valid the cycle after addrb
//   m_data, m_valid   output stream (FIFO head)
//   m_ready           output stream ready from the consumer
module mem_burst_reader #(
  parameter int  DATA_WIDTH = 8,
  parameter int  DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [DATA_WIDTH-1:0] doutb,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  typedef enum logic [1:0] {IDLE, READ, DONE} state_t;

  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH:0]     issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]     out_cnt_q, out_cnt_d;
  logic                    inflight_q, inflight_d;
  logic [1:0]              buf_count_q, buf_count_d;
  logic [DATA_WIDTH-1:0]   buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0]   buf1_q, buf1_d;

  logic                    pop;
  logic                    push;
  logic                    issue;
  logic                    last_pop;
  logic [2:0]              occupancy;

  assign m_valid = (buf_count_q != 2'd0);
  assign m_data  = buf0_q;
  assign addrb   = rd_addr_q;

  assign pop      = m_valid & m_ready;
  assign push     = inflight_q;
  assign last_pop = pop && (out_cnt_q == CNT_ONE);

  // Words that will occupy the FIFO after this cycle, counting the read still
  // in flight; issuing only while this is below 2 keeps the FIFO from
  // overflowing even when the consumer stalls.
  assign occupancy = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == READ) && (issue_cnt_q != '0) && (occupancy < 3'd2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (len != '0) ? READ : DONE;
      READ:    if (last_pop) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    busy = (state_q == READ);
    done = (state_q == DONE);
  end

  // Address/counter and FIFO next-state
  always_comb begin
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    inflight_d  = issue;
    buf_count_d = buf_count_q;
    buf0_d      = buf0_q;
    buf1_d      = buf1_q;

    if ((state_q == IDLE) && start && (len != '0)) begin
      rd_addr_d   = start_addr;
      issue_cnt_d = len;
      out_cnt_d   = len;
    end

    if (issue) begin
      rd_addr_d   = (rd_addr_q == ADDR_LAST) ? '0 : rd_addr_q + ADDR_ONE;
      issue_cnt_d = issue_cnt_q - CNT_ONE;
    end

    if (pop) out_cnt_d = out_cnt_q - CNT_ONE;

    // Entry 0 is always the head; a pop shifts entry 1 forward and a
    // simultaneous push lands behind whatever remains.
    unique case ({push, pop})
      2'b11: begin
        if (buf_count_q == 2'd1) begin
          buf0_d = doutb;
        end else begin
          buf0_d = buf1_q;
          buf1_d = doutb;
        end
      end
      2'b01: begin
        buf0_d      = buf1_q;
        buf_count_d = buf_count_q - 2'd1;
      end
      2'b10: begin
        if (buf_count_q == 2'd0) buf0_d = doutb;
        else                     buf1_d = doutb;
        buf_count_d = buf_count_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q   <= '0;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
      buf_count_q <= 2'd0;
      buf0_q      <= '0;
      buf1_q      <= '0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
      buf_count_q <= buf_count_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
module tb_mem_burst_reader;

  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic          busy;
  logic          done;
  logic [AW-1:0] addrb;
  logic [DW-1:0] doutb;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;

  logic [DW-1:0] mem [0:DEPTH-1];

  int passed = 0;
  int total  = 0;

  mem_burst_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .busy(busy), .done(done), .addrb(addrb), .doutb(doutb),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // Registered-read RAM port B: one cycle of latency.
  always @(posedge clk) doutb <= mem[addrb];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Fixed-ready burst checked cycle by cycle against the stated latency:
  // issues in cycles 1..n, data in cycles 3..n+2, done in cycle n+3.
  task automatic directed(input int addr, input int n);
    start = 1'b1; start_addr = AW'(addr); len = (AW + 1)'(n); m_ready = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= n + 3; k++) begin
      chk($sformatf("dir_busy_c%0d", k), busy, (k <= n + 2));
      chk($sformatf("dir_done_c%0d", k), done, (k == n + 3));
      chk($sformatf("dir_valid_c%0d", k), m_valid, (k >= 3 && k <= n + 2));
      if (k >= 3 && k <= n + 2)
        chk($sformatf("dir_data_c%0d", k), m_data, mem[(addr + k - 3) % DEPTH]);
      if (k <= n)
        chk($sformatf("dir_addrb_c%0d", k), addrb, (addr + k - 1) % DEPTH);
      step();
    end
    chk("dir_idle_busy", busy, 0);
    chk("dir_idle_done", done, 0);
    chk("dir_idle_valid", m_valid, 0);
  endtask

  // General burst against a queue model: every handshaked word must be the
  // next one in address order; stalled words must hold.
  task automatic run_burst(input int addr, input int n, input bit rnd_ready,
                           input bit dbl_start, input int exp_done);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] prev_data;
    logic [AW-1:0] addr_before;
    bit prev_stall;
    int cyc, got, dones, done_cyc;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(addr + i) % DEPTH]);
    addr_before = addrb;
    start = 1'b1; start_addr = AW'(addr); len = (AW + 1)'(n);
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    step();
    cyc = 1; got = 0; dones = 0; done_cyc = -1; prev_stall = 0; prev_data = '0;
    while (cyc < 400) begin
      if (dbl_start && cyc == 2) begin
        start = 1'b1; start_addr = AW'(addr ^ 5); len = 5'd9;
      end else begin
        start = 1'b0;
      end
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
        break;
      end
      chk("burst_busy", busy, 1);
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 1, 0);
        else chk("burst_data", m_data, exp_q.pop_front());
        got++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      step();
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", dones, 1);
    chk("word_count", got, n);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    chk("done_busy", busy, 0);
    chk("done_valid", m_valid, 0);
    if (n == 0) chk("len0_no_issue_addrb", addrb, addr_before);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_done", done, 0);
      chk("post_valid", m_valid, 0);
      chk("post_busy", busy, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(8'hA0 + i);
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_addrb", addrb, 0);
    rst = 1'b0;
    step();

    // Basic burst and wrap-around with exact cycle timing.
    directed(3, 4);
    directed(14, 4);

    // Zero-length command: done in cycle 1, nothing issued or streamed.
    run_burst(5, 0, 1'b0, 1'b0, 1);

    // Second start while busy is ignored.
    run_burst(2, 4, 1'b0, 1'b1, 7);

    // Full-depth burst with random backpressure.
    run_burst(9, 16, 1'b1, 1'b0, -1);

    // Reset in the middle of a stalled burst.
    start = 1'b1; start_addr = 4'd0; len = 5'd16; m_ready = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b1;
    step(); step();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_valid", m_valid, 0);
    chk("midrst_data", m_data, 0);
    chk("midrst_addrb", addrb, 0);
    rst = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrst_no_done", done, 0);
      chk("midrst_no_valid", m_valid, 0);
      chk("midrst_no_busy", busy, 0);
    end

    // Random contents, addresses and lengths (up to 2*DEPTH-1).
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int t = 0; t < 12; t++)
      run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 2 * DEPTH - 1)),
                1'b1, t[0], -1);
    run_burst(int'($urandom_range(0, DEPTH - 1)), 2 * DEPTH - 1, 1'b0, 1'b0, 2 * DEPTH - 1 + 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
